// File: rtl/conv_pkg.sv
// Shared types, sizing helpers and the output saturation function for the
// streaming convolution engine.
package conv_pkg;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefAccW  = 32;

   typedef logic signed [DefDataW-1:0] pixel_t;
   typedef logic signed [DefAccW-1:0]  acc_t;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} conv_state_e;

   function automatic int unsigned out_dim(int unsigned mapsize, int unsigned ksize);
      return mapsize - ksize + 1;
   endfunction

   function automatic int unsigned tree_levels(int unsigned ksize);
      return $clog2(ksize * ksize);
   endfunction

   // Accepting cycle to mem_wr_en: product stage, adder-tree levels, output stage.
   function automatic int unsigned pipe_lat(int unsigned ksize);
      return 2 + tree_levels(ksize);
   endfunction

   function automatic longint sat(longint v, int unsigned width);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (width - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-row delay line: dout is the sample shifted in DEPTH accepted pixels ago.
module conv_line_buffer #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (shift) begin
         mem_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
      end
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK valid-padding convolution: line buffers feed a window, registered
// products and adder tree, then ReLU/saturation and a linear-address write port.
module conv_stream_engine
   import conv_pkg::*;
#(
   parameter int unsigned MAPSIZE = 32,
   parameter int unsigned KSIZE   = 5,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ACC_W   = 32,
   localparam int unsigned OUT_DIM = out_dim(MAPSIZE, KSIZE),
   localparam int unsigned AW      = $clog2(OUT_DIM * OUT_DIM)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      relu_en,
   input  logic [KSIZE*KSIZE*DATA_W-1:0] weights,
   input  logic                      data_valid_in,
   input  logic [DATA_W-1:0]         pixel_in,
   output logic                      mem_wr_en,
   output logic [AW-1:0]             mem_wr_addr,
   output logic [ACC_W-1:0]          mem_wr_data,
   output logic                      busy,
   output logic                      all_done
);

   localparam int unsigned NTAP = KSIZE * KSIZE;
   localparam int unsigned LVLS = tree_levels(KSIZE);
   localparam int unsigned NP   = 1 << LVLS;
   localparam int unsigned PW   = 2 * DATA_W;
   localparam int unsigned SW   = PW + LVLS;
   localparam int unsigned NPIX = MAPSIZE * MAPSIZE;
   localparam int unsigned NOUT = OUT_DIM * OUT_DIM;
   localparam int unsigned CW   = $clog2(MAPSIZE);
   localparam int unsigned PCW  = $clog2(NPIX + 1);

   conv_state_e state_q, state_d;

   logic signed [DATA_W-1:0] w_q   [KSIZE][KSIZE];
   logic signed [DATA_W-1:0] win_q [KSIZE][KSIZE];
   logic signed [DATA_W-1:0] win_d [KSIZE][KSIZE];
   logic [KSIZE-1:0][DATA_W-1:0] tap;
   logic signed [PW-1:0]     prod_q [NTAP];
   logic signed [SW-1:0]     lvl0   [NP];
   logic signed [SW-1:0]     tree_q [LVLS][NP];
   logic [LVLS:0]            vld_q;
   logic                     relu_q;
   logic [CW-1:0]            row_q, col_q;
   logic [PCW-1:0]           pix_cnt_q;
   logic [AW-1:0]            wr_cnt_q;
   logic                     accept, win_ok, last_pix, last_wr;
   logic signed [SW-1:0]     sum, sum_relu;
   logic [ACC_W-1:0]         result;

   assign busy     = (state_q == StRun) || (state_q == StDrain);
   assign all_done = (state_q == StDone);
   // A start in the same cycle belongs to the new frame, so it blocks acceptance.
   assign accept   = busy && data_valid_in && !start && (pix_cnt_q < PCW'(NPIX));
   assign win_ok   = (row_q >= CW'(KSIZE - 1)) && (col_q >= CW'(KSIZE - 1));
   assign last_pix = (pix_cnt_q == PCW'(NPIX - 1));
   assign last_wr  = mem_wr_en && (mem_wr_addr == AW'(NOUT - 1));

   // tap[KSIZE-1] is the current row; tap[i] is delayed by KSIZE-1-i rows.
   assign tap[KSIZE-1] = pixel_in;
   for (genvar k = 0; k < KSIZE - 1; k++) begin : g_lb
      conv_line_buffer #(
         .DEPTH(MAPSIZE),
         .WIDTH(DATA_W)
      ) u_line_buffer (
         .clk  (clk),
         .rst_n(rst_n),
         .shift(accept),
         .din  (tap[KSIZE-1-k]),
         .dout (tap[KSIZE-2-k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         relu_q    <= 1'b0;
         row_q     <= '0;
         col_q     <= '0;
         pix_cnt_q <= '0;
         for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++) w_q[i][j] <= '0;
      end else if (start) begin
         relu_q    <= relu_en;
         row_q     <= '0;
         col_q     <= '0;
         pix_cnt_q <= '0;
         for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
               w_q[i][j] <= weights[(i*KSIZE+j)*DATA_W +: DATA_W];
      end else if (accept) begin
         pix_cnt_q <= pix_cnt_q + PCW'(1);
         if (col_q == CW'(MAPSIZE - 1)) begin
            col_q <= '0;
            row_q <= row_q + CW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE - 1; j++) win_d[i][j] = win_q[i][j+1];
            win_d[i][KSIZE-1] = $signed(tap[i]);
         end
      end
   end

   // Products are taken from the next window so the multiply stage lands on the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++) win_q[i][j] <= '0;
         for (int n = 0; n < NTAP; n++) prod_q[n] <= '0;
      end else begin
         win_q <= win_d;
         for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
               prod_q[i*KSIZE+j] <= PW'(win_d[i][j]) * PW'(w_q[i][j]);
      end
   end

   always_comb begin
      for (int n = 0; n < NP; n++) lvl0[n] = '0;
      for (int n = 0; n < NTAP; n++) lvl0[n] = SW'(prod_q[n]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < LVLS; l++)
            for (int n = 0; n < NP; n++) tree_q[l][n] <= '0;
      end else begin
         for (int n = 0; n < NP / 2; n++) tree_q[0][n] <= lvl0[2*n] + lvl0[2*n+1];
         for (int n = NP / 2; n < NP; n++) tree_q[0][n] <= '0;
         for (int l = 1; l < LVLS; l++) begin
            for (int n = 0; n < NP / 2; n++)
               tree_q[l][n] <= tree_q[l-1][2*n] + tree_q[l-1][2*n+1];
            for (int n = NP / 2; n < NP; n++) tree_q[l][n] <= '0;
         end
      end
   end

   always_comb begin
      sum      = tree_q[LVLS-1][0];
      sum_relu = (relu_q && sum[SW-1]) ? '0 : sum;
      result   = ACC_W'(sat(longint'(sum_relu), ACC_W));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q       <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         wr_cnt_q    <= '0;
      end else if (start) begin
         vld_q     <= '0;
         mem_wr_en <= 1'b0;
         wr_cnt_q  <= '0;
      end else begin
         vld_q     <= {vld_q[LVLS-1:0], accept & win_ok};
         mem_wr_en <= vld_q[LVLS];
         if (vld_q[LVLS]) begin
            mem_wr_addr <= wr_cnt_q;
            mem_wr_data <= result;
            wr_cnt_q    <= wr_cnt_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun:   if (accept && last_pix) state_d = StDrain;
         StDrain: if (last_wr) state_d = StDone;
         default: state_d = state_q;
      endcase
      if (start) state_d = StRun;
   end

endmodule
